inta_sequencer: RTL and testbench
=================================

# inta_sequencer

Interrupt-acknowledge sequencer for the 8259-style controller. It takes the masked request vector from the IRR and resolves priority with fixed order (IR0 highest) under the fully-nested rule. It drives INT to the CPU, runs the two-pulse INTA handshake, maintains the In-Service Register (ISR) and puts the interrupt vector on the data bus. It sits between the IRR and the CPU bus interface; EOI commands reach it from the control logic.

## Interface
- Parameters: none.
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- IRR  in  8  masked interrupt requests; bit i = IR line i.
- INTA_N  in  1  CPU acknowledge strobe, active low, synchronous to clk, each low phase ≥1 cycle.
- VECTOR_BASE  in  5  ICW2 T7..T3 bits.
- AUTO_EOI  in  1  1 = clear ISR bit automatically at end of second INTA.
- EOI_CMD  in  1  one-cycle EOI command strobe.
- EOI_SPECIFIC  in  1  qualifies EOI_CMD: 1 = specific, 0 = non-specific.
- EOI_LEVEL  in  3  level cleared by a specific EOI.
- INT  out  1  interrupt request to CPU, registered.
- ISR  out  8  in-service register, registered.
- D_OUT  out  8  vector byte, registered.
- D_OUT_EN  out  1  data-bus drive enable for D_OUT, registered.

## Operation
- Priority: IR0 highest, IR7 lowest. `req_lvl` is the lowest-index set bit of IRR. `isr_lvl` is the lowest-index set bit of ISR (8 if none).
- A request is eligible only if `req_lvl < isr_lvl`. An equal or lower-priority request is blocked while a higher or equal level is in service.
- The FSM has these states: IDLE, ACK1, WAIT2, ACK2.
- IDLE:
  - INT = (eligible request exists).
  - On an INTA_N falling edge, latch `cur_lvl` = `req_lvl` if eligible, else spurious (`cur_lvl` = 7, ISR unchanged).
  - If not spurious, set ISR[`cur_lvl`].
  - Clear INT and go to ACK1.
- ACK1: on an INTA_N rising edge, go to WAIT2.
- WAIT2: on an INTA_N falling edge, go to ACK2; D_OUT = {VECTOR_BASE, `cur_lvl`}; D_OUT_EN = 1.
- ACK2:
  - On an INTA_N rising edge, D_OUT_EN = 0 and go to IDLE.
  - If AUTO_EOI = 1 and not spurious, clear ISR[`cur_lvl`] at the same edge.
- An INTA_N falling edge in IDLE with no eligible request is still accepted as a spurious sequence (vector level 7, no ISR change).
- Edge detection: a registered copy `inta_q` of INTA_N. Fall = `inta_q`=1 & INTA_N=0. Rise = `inta_q`=0 & INTA_N=1. `inta_q` resets to 1.
- EOI, accepted in any state when EOI_CMD = 1:
  - Specific EOI clears ISR[EOI_LEVEL].
  - Non-specific EOI clears ISR[`isr_lvl`], or does nothing if ISR = 0.
  - `isr_lvl` is computed from ISR before the current edge.
- Simultaneous EOI and ISR set (or auto-EOI clear) in one cycle: apply the EOI clear and the FSM set/clear together.
  - A bit set this cycle is never cleared by a non-specific EOI of the same cycle.
  - A specific EOI naming the same level as a bit being set this cycle loses: the bit ends up set.
- Requests that drop after the first INTA do not alter `cur_lvl`. Requests that change during ACK1/WAIT2/ACK2 do not raise INT until the FSM is back in IDLE.
- Reset (any state, including mid-sequence): state = IDLE, ISR = 0, INT = 0, D_OUT = 0x00, D_OUT_EN = 0, `cur_lvl` = 0, `inta_q` = 1.

## Timing
- INT: 1-cycle latency from IRR/ISR change in IDLE. It drops the cycle after the first INTA falling edge is detected.
- ISR set is visible the cycle after the first INTA falling edge is detected.
- D_OUT/D_OUT_EN are valid the cycle after the second falling edge is detected. They hold until the cycle after the second rising edge is detected.
- Auto-EOI clear is visible the cycle after the second rising edge. EOI_CMD effects are visible the next cycle.
- INT can reassert at the earliest the cycle after returning to IDLE, i.e. 2 cycles after the second rising edge.
- Minimum full sequence: 4 INTA_N transitions, no timeout; the FSM waits indefinitely in any state.

## Test plan
- IRR=0x24, ISR=0, VECTOR_BASE=0x11, two INTA pulses -> INT=1 then 0; ISR=0x04; D_OUT=0x8A with D_OUT_EN during second pulse; ISR still 0x04 after the sequence (AUTO_EOI=0).
- ISR=0x04, IRR=0x08 -> INT stays 0. Then IRR=0x02 -> INT=1; acknowledge gives ISR=0x06 and D_OUT low bits = 1.
- IRR=0x10, INT=1, IRR drops to 0 before the first INTA -> spurious: D_OUT = {VECTOR_BASE, 3'b111}; ISR unchanged.
- ISR=0x06, non-specific EOI -> ISR=0x04. Then specific EOI with EOI_LEVEL=2 -> ISR=0x00.
- AUTO_EOI=1, IRR=0x80, full sequence -> ISR=0x80 between pulses, 0x00 after the second rising edge, INT reasserts 2 cycles later.
- Assert reset during WAIT2 with ISR=0x01 -> next cycle ISR=0, INT=0, D_OUT_EN=0. A following INTA_N low is treated as a new first pulse.

Source files
------------

// File: rtl/inta_sequencer_if.sv
// Bus bundle between the 8259-style control/IRR logic, the CPU strobe and the INTA sequencer.
// The sequencer connects through the slave modport; the driving side uses master.
interface inta_sequencer_if;
    logic [7:0] IRR;
    logic       INTA_N;
    logic [4:0] VECTOR_BASE;
    logic       AUTO_EOI;
    logic       EOI_CMD;
    logic       EOI_SPECIFIC;
    logic [2:0] EOI_LEVEL;
    logic       INT;
    logic [7:0] ISR;
    logic [7:0] D_OUT;
    logic       D_OUT_EN;

    modport master (
        output IRR, INTA_N, VECTOR_BASE, AUTO_EOI, EOI_CMD, EOI_SPECIFIC, EOI_LEVEL,
        input  INT, ISR, D_OUT, D_OUT_EN
    );

    modport slave (
        input  IRR, INTA_N, VECTOR_BASE, AUTO_EOI, EOI_CMD, EOI_SPECIFIC, EOI_LEVEL,
        output INT, ISR, D_OUT, D_OUT_EN
    );
endinterface

// File: rtl/inta_sequencer.sv
// Interrupt-acknowledge sequencer: fixed-priority fully-nested resolution, two-pulse INTA
// handshake, in-service register maintenance and vector drive.
module inta_sequencer (
    input logic               clk,
    input logic               reset,
    inta_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {StIdle, StAck1, StWait2, StAck2} state_e;

    state_e     state_q, state_d;
    logic       inta_q;
    logic [2:0] cur_lvl_q, cur_lvl_d;
    logic       spurious_q, spurious_d;
    logic [7:0] isr_q, isr_d;
    logic       int_q, int_d;
    logic [7:0] d_out_q, d_out_d;
    logic       d_out_en_q, d_out_en_d;

    logic       fall, rise;
    logic       req_valid;
    logic [2:0] req_lvl;
    logic [3:0] isr_lvl;
    logic       eligible;
    logic [7:0] set_mask, fsm_clr, eoi_clr;

    assign fall = inta_q & ~bus.INTA_N;
    assign rise = ~inta_q & bus.INTA_N;

    // Lowest set index wins; isr_lvl of 8 means nothing in service.
    always_comb begin
        req_valid = 1'b0;
        req_lvl   = 3'd0;
        isr_lvl   = 4'd8;
        for (int i = 7; i >= 0; i--) begin
            if (bus.IRR[i]) begin
                req_valid = 1'b1;
                req_lvl   = 3'(i);
            end
            if (isr_q[i]) begin
                isr_lvl = 4'(i);
            end
        end
    end

    assign eligible = req_valid && ({1'b0, req_lvl} < isr_lvl);

    always_comb begin
        state_d    = state_q;
        cur_lvl_d  = cur_lvl_q;
        spurious_d = spurious_q;
        int_d      = 1'b0;
        d_out_d    = d_out_q;
        d_out_en_d = d_out_en_q;
        set_mask   = 8'h00;
        fsm_clr    = 8'h00;
        unique case (state_q)
            StIdle: begin
                int_d = eligible;
                if (fall) begin
                    int_d      = 1'b0;
                    state_d    = StAck1;
                    spurious_d = ~eligible;
                    cur_lvl_d  = eligible ? req_lvl : 3'd7;
                    if (eligible) begin
                        set_mask = 8'd1 << req_lvl;
                    end
                end
            end
            StAck1: begin
                if (rise) begin
                    state_d = StWait2;
                end
            end
            StWait2: begin
                if (fall) begin
                    state_d    = StAck2;
                    d_out_d    = {bus.VECTOR_BASE, cur_lvl_q};
                    d_out_en_d = 1'b1;
                end
            end
            StAck2: begin
                if (rise) begin
                    state_d    = StIdle;
                    d_out_en_d = 1'b0;
                    if (bus.AUTO_EOI && !spurious_q) begin
                        fsm_clr = 8'd1 << cur_lvl_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Set is applied after all clears so a bit entering service this cycle always survives.
    always_comb begin
        eoi_clr = 8'h00;
        if (bus.EOI_CMD) begin
            if (bus.EOI_SPECIFIC) begin
                eoi_clr = 8'd1 << bus.EOI_LEVEL;
            end else if (!isr_lvl[3]) begin
                eoi_clr = 8'd1 << isr_lvl[2:0];
            end
        end
        isr_d = (isr_q & ~(eoi_clr | fsm_clr)) | set_mask;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            inta_q     <= 1'b1;
            cur_lvl_q  <= 3'd0;
            spurious_q <= 1'b0;
            isr_q      <= 8'h00;
            int_q      <= 1'b0;
            d_out_q    <= 8'h00;
            d_out_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            inta_q     <= bus.INTA_N;
            cur_lvl_q  <= cur_lvl_d;
            spurious_q <= spurious_d;
            isr_q      <= isr_d;
            int_q      <= int_d;
            d_out_q    <= d_out_d;
            d_out_en_q <= d_out_en_d;
        end
    end

    assign bus.INT      = int_q;
    assign bus.ISR      = isr_q;
    assign bus.D_OUT    = d_out_q;
    assign bus.D_OUT_EN = d_out_en_q;
endmodule

// File: tb/tb_inta_sequencer.sv
// Bench for inta_sequencer: directed scenarios then random traffic, all checked against a
// transaction-level model of the in-service register and priority rules.
module tb_inta_sequencer;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    inta_sequencer_if bus ();

    inta_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] m_isr;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            if (v[i]) return i;
        end
        return 8;
    endfunction

    function automatic logic exp_int();
        return lowest(bus.IRR) < lowest(m_isr);
    endfunction

    function automatic logic [7:0] eoi_mask(input logic spec, input logic [2:0] lvl,
                                            input logic [7:0] isr);
        logic [7:0] m;
        m = 8'h00;
        if (spec) m[lvl] = 1'b1;
        else if (lowest(isr) < 8) m[3'(lowest(isr))] = 1'b1;
        return m;
    endfunction

    task automatic eoi(input logic spec, input logic [2:0] lvl);
        m_isr = m_isr & ~eoi_mask(spec, lvl, m_isr);
        bus.EOI_CMD      = 1'b1;
        bus.EOI_SPECIFIC = spec;
        bus.EOI_LEVEL    = lvl;
        cycle();
        bus.EOI_CMD = 1'b0;
        check("eoi_isr", bus.ISR, m_isr);
    endtask

    // Full two-pulse acknowledge; optional EOI alongside the first fall, optional IRR change
    // once the sequence has started.
    task automatic run_ack(input logic eoi_en, input logic eoi_spec, input logic [2:0] eoi_lvl,
                           input logic new_irr_en, input logic [7:0] new_irr);
        int         req;
        logic       spur;
        logic [2:0] lvl;
        logic [7:0] setm;
        req  = lowest(bus.IRR);
        spur = !(req < lowest(m_isr));
        lvl  = spur ? 3'd7 : 3'(req);
        setm = 8'h00;
        if (!spur) setm[lvl] = 1'b1;
        if (eoi_en) m_isr = m_isr & ~eoi_mask(eoi_spec, eoi_lvl, m_isr);
        m_isr = m_isr | setm;

        bus.EOI_CMD      = eoi_en;
        bus.EOI_SPECIFIC = eoi_spec;
        bus.EOI_LEVEL    = eoi_lvl;
        bus.INTA_N       = 1'b0;
        cycle();
        bus.EOI_CMD = 1'b0;
        check("ack1_int", bus.INT, 0);
        check("ack1_isr", bus.ISR, m_isr);
        check("ack1_den", bus.D_OUT_EN, 0);
        if (new_irr_en) bus.IRR = new_irr;

        bus.INTA_N = 1'b1;
        cycle();
        check("wait2_int", bus.INT, 0);

        bus.INTA_N = 1'b0;
        cycle();
        check("ack2_dout", bus.D_OUT, {bus.VECTOR_BASE, lvl});
        check("ack2_den", bus.D_OUT_EN, 1);
        check("ack2_int", bus.INT, 0);

        bus.INTA_N = 1'b1;
        cycle();
        if (bus.AUTO_EOI && !spur) m_isr[lvl] = 1'b0;
        check("end_den", bus.D_OUT_EN, 0);
        check("end_isr", bus.ISR, m_isr);
        check("end_int", bus.INT, 0);

        cycle();
        check("idle_int", bus.INT, exp_int());
    endtask

    initial begin
        reset            = 1'b1;
        bus.IRR          = 8'h00;
        bus.INTA_N       = 1'b1;
        bus.VECTOR_BASE  = 5'h00;
        bus.AUTO_EOI     = 1'b0;
        bus.EOI_CMD      = 1'b0;
        bus.EOI_SPECIFIC = 1'b0;
        bus.EOI_LEVEL    = 3'd0;
        m_isr            = 8'h00;
        cycle();
        cycle();
        reset = 1'b0;
        check("rst_int", bus.INT, 0);
        check("rst_isr", bus.ISR, 0);
        check("rst_dout", bus.D_OUT, 0);
        check("rst_den", bus.D_OUT_EN, 0);

        // Basic acknowledge of IR2 with IR5 pending.
        bus.VECTOR_BASE = 5'h11;
        bus.IRR         = 8'h24;
        cycle();
        check("t1_int", bus.INT, 1);
        run_ack(1'b0, 1'b0, 3'd0, 1'b0, 8'h00);
        check("t1_isr", bus.ISR, 8'h04);

        // Lower priority blocked, higher priority nests.
        bus.IRR = 8'h08;
        cycle();
        check("t2_blocked", bus.INT, 0);
        bus.IRR = 8'h02;
        cycle();
        check("t2_int", bus.INT, 1);
        run_ack(1'b0, 1'b0, 3'd0, 1'b0, 8'h00);
        check("t2_isr", bus.ISR, 8'h06);

        eoi(1'b0, 3'd0);
        check("t4_ns_eoi", bus.ISR, 8'h04);
        eoi(1'b1, 3'd2);
        check("t4_sp_eoi", bus.ISR, 8'h00);

        // Request withdrawn before the first INTA: spurious vector 7.
        bus.IRR = 8'h10;
        cycle();
        check("t3_int", bus.INT, 1);
        bus.IRR = 8'h00;
        cycle();
        run_ack(1'b0, 1'b0, 3'd0, 1'b0, 8'h00);
        check("t3_isr", bus.ISR, 8'h00);

        // Auto-EOI: ISR clears at the end and INT returns two cycles after the last rise.
        bus.AUTO_EOI = 1'b1;
        bus.IRR      = 8'h80;
        cycle();
        check("t5_int", bus.INT, 1);
        run_ack(1'b0, 1'b0, 3'd0, 1'b0, 8'h00);
        check("t5_isr", bus.ISR, 8'h00);
        check("t5_reint", bus.INT, 1);
        bus.AUTO_EOI = 1'b0;

        // EOI in the same cycle as an ISR set.
        bus.IRR = 8'h04;
        cycle();
        run_ack(1'b0, 1'b0, 3'd0, 1'b0, 8'h00);
        bus.IRR = 8'h01;
        cycle();
        run_ack(1'b1, 1'b1, 3'd0, 1'b0, 8'h00);
        check("sim_sp_isr", bus.ISR, 8'h05);
        eoi(1'b0, 3'd0);
        run_ack(1'b1, 1'b0, 3'd0, 1'b0, 8'h00);
        check("sim_ns_isr", bus.ISR, 8'h01);

        // Reset in WAIT2, then a fresh first pulse.
        bus.INTA_N = 1'b0;
        cycle();
        bus.INTA_N = 1'b1;
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        m_isr = 8'h00;
        check("t6_isr", bus.ISR, 0);
        check("t6_int", bus.INT, 0);
        check("t6_den", bus.D_OUT_EN, 0);
        check("t6_dout", bus.D_OUT, 0);
        cycle();
        check("t6_int2", bus.INT, 1);
        run_ack(1'b0, 1'b0, 3'd0, 1'b0, 8'h00);
        check("t6_isr2", bus.ISR, 8'h01);

        for (int n = 0; n < 80; n++) begin
            bus.VECTOR_BASE = 5'($urandom);
            bus.AUTO_EOI    = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: begin
                    bus.IRR = 8'($urandom & $urandom & $urandom);
                    cycle();
                    check("rnd_int", bus.INT, exp_int());
                end
                1: run_ack($urandom_range(0, 3) == 0, 1'($urandom), 3'($urandom),
                           1'($urandom), 8'($urandom & $urandom));
                2: eoi(1'($urandom), 3'($urandom));
                default: begin
                    cycle();
                    check("rnd_idle_int", bus.INT, exp_int());
                    check("rnd_idle_isr", bus.ISR, m_isr);
                end
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
